// File: rtl/mux_pipe_nx1.sv
// Registered N:1 channel mux with valid/ready handshake and a transfer counter.
// Define MUX_PIPE_SKID_EN to add a one-entry skid buffer so in_ready comes from a flop.
module mux_pipe_nx1 #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned INPUTS = 8,
    parameter int unsigned SEL_W  = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [INPUTS*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [15:0]             xfer_count
);

    localparam int unsigned CNT_W = 16;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] sel;
        logic             err;
    } beat_t;

    beat_t             in_beat_c;
    beat_t             out_q;
    logic              out_valid_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              accept_c;
    logic              xfer_c;

    // Channel select; out-of-range indices yield a zero beat flagged as an error.
    always_comb begin
        in_beat_c     = '0;
        in_beat_c.sel = sel;
        if (32'(sel) >= INPUTS) begin
            in_beat_c.err = 1'b1;
        end else begin
            for (int unsigned k = 0; k < INPUTS; k++) begin
                if (32'(sel) == k) begin
                    in_beat_c.data = in_data[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign accept_c = in_valid && in_ready;
    assign xfer_c   = out_valid_q && out_ready;

`ifdef MUX_PIPE_SKID_EN
    beat_t skid_q;
    logic  skid_valid_q;

    // Ready is the registered skid-empty flag, masked while reset is held.
    assign in_ready = !reset && !skid_valid_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else begin
                out_valid_q <= accept_c;
                if (accept_c) begin
                    out_q <= in_beat_c;
                end
            end
        end else if (accept_c) begin
            // Output stalled: park the new beat until the next transfer.
            skid_q       <= in_beat_c;
            skid_valid_q <= 1'b1;
        end
    end
`else
    assign in_ready = !reset && (!out_valid_q || out_ready);

    always_ff @(posedge clock) begin
        if (reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (!out_valid_q || out_ready) begin
            out_valid_q <= accept_c;
            if (accept_c) begin
                out_q <= in_beat_c;
            end
        end
    end
`endif

    // Completed output transfers, wrapping at 2^16.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (xfer_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign out_data   = out_q.data;
    assign out_sel    = out_q.sel;
    assign out_err    = out_q.err;
    assign out_valid  = out_valid_q;
    assign xfer_count = cnt_q;

endmodule

// File: tb/tb_mux_pipe_nx1.sv
// Bench for mux_pipe_nx1: directed scenarios plus random traffic against a queue model.
module tb_mux_pipe_nx1;

    localparam int W  = 32;
    localparam int N  = 8;
    localparam int S  = 3;
    localparam int BW = 16;
    localparam int BN = 5;
`ifdef MUX_PIPE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic            a_reset, a_in_valid, a_in_ready, a_out_err, a_out_valid, a_out_ready;
    logic [N*W-1:0]  a_in_data;
    logic [S-1:0]    a_sel, a_out_sel;
    logic [W-1:0]    a_out_data;
    logic [15:0]     a_xfer_count;

    logic            b_reset, b_in_valid, b_in_ready, b_out_err, b_out_valid, b_out_ready;
    logic [BN*BW-1:0] b_in_data;
    logic [S-1:0]    b_sel, b_out_sel;
    logic [BW-1:0]   b_out_data;
    logic [15:0]     b_xfer_count;

    mux_pipe_nx1 #(.WIDTH(W), .INPUTS(N), .SEL_W(S)) dut_a (
        .clock(clock), .reset(a_reset), .in_data(a_in_data), .sel(a_sel),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
        .out_sel(a_out_sel), .out_err(a_out_err), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .xfer_count(a_xfer_count)
    );

    mux_pipe_nx1 #(.WIDTH(BW), .INPUTS(BN), .SEL_W(S)) dut_b (
        .clock(clock), .reset(b_reset), .in_data(b_in_data), .sel(b_sel),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
        .out_sel(b_out_sel), .out_err(b_out_err), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .xfer_count(b_xfer_count)
    );

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [W-1:0] d;
        logic [S-1:0] s;
        logic         e;
    } beat_t;

    beat_t       q[$];
    logic [15:0] m_cnt = '0;
    int          total = 0;
    int          dut_acc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Model: a FIFO of held beats, depth 1 (plain) or 2 (skid).
    function automatic logic m_ready();
        if (a_reset) return 1'b0;
        if (CAP == 2) return q.size() < 2;
        return (q.size() == 0) || a_out_ready;
    endfunction

    function automatic beat_t m_beat();
        beat_t b;
        b.s = a_sel;
        if (int'(a_sel) >= N) begin
            b.d = '0;
            b.e = 1'b1;
        end else begin
            b.d = a_in_data[a_sel*W +: W];
            b.e = 1'b0;
        end
        return b;
    endfunction

    task automatic step();
        logic rdy;
        @(negedge clock);
        check("in_ready", 64'(a_in_ready), 64'(m_ready()));
        check("out_valid", 64'(a_out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            check("out_data", 64'(a_out_data), 64'(q[0].d));
            check("out_sel", 64'(a_out_sel), 64'(q[0].s));
            check("out_err", 64'(a_out_err), 64'(q[0].e));
        end
        check("xfer_count", 64'(a_xfer_count), 64'(m_cnt));
        if (a_in_valid && a_in_ready) dut_acc++;
        @(posedge clock);
        rdy = m_ready();
        if (a_reset) begin
            q.delete();
            m_cnt = '0;
        end else begin
            if (q.size() > 0 && a_out_ready) begin
                void'(q.pop_front());
                m_cnt = m_cnt + 16'd1;
                total++;
            end
            if (a_in_valid && rdy) q.push_back(m_beat());
        end
        #1;
    endtask

    task automatic do_reset(input int cycles);
        a_reset = 1'b1;
        for (int i = 0; i < cycles; i++) step();
        a_reset = 1'b0;
        total = 0;
    endtask

    initial begin
        int acc0;
        a_reset = 1'b1; a_in_valid = 1'b0; a_out_ready = 1'b1; a_sel = '0; a_in_data = '0;
        b_reset = 1'b1; b_in_valid = 1'b0; b_out_ready = 1'b1; b_sel = '0;
        for (int k = 0; k < BN; k++) b_in_data[k*BW +: BW] = 16'(16'h1000 + k);

        // Reset for two cycles.
        do_reset(2);
        a_reset = 1'b1;
        check("rst_in_ready", 64'(a_in_ready), 64'(0));
        a_reset = 1'b0;
        check("rst_out_valid", 64'(a_out_valid), 64'(0));
        check("rst_out_data", 64'(a_out_data), 64'(0));
        check("rst_out_sel", 64'(a_out_sel), 64'(0));
        check("rst_out_err", 64'(a_out_err), 64'(0));
        check("rst_xfer", 64'(a_xfer_count), 64'(0));

        // Single beat from channel 5.
        a_in_data[5*W +: W] = 32'hDEADBEEF;
        a_sel = 3'd5; a_in_valid = 1'b1; a_out_ready = 1'b1;
        step();
        a_in_valid = 1'b0;
        check("single_valid", 64'(a_out_valid), 64'(1));
        check("single_data", 64'(a_out_data), 64'(32'hDEADBEEF));
        check("single_sel", 64'(a_out_sel), 64'(5));
        step();
        check("single_valid_drop", 64'(a_out_valid), 64'(0));
        check("single_xfer", 64'(a_xfer_count), 64'(1));

        // Streaming 8 beats with no bubbles.
        do_reset(1);
        for (int k = 0; k < N; k++) a_in_data[k*W +: W] = 32'(k * 32'h11111111);
        for (int k = 0; k < N; k++) begin
            a_sel = 3'(k); a_in_valid = 1'b1;
            step();
            check("stream_valid", 64'(a_out_valid), 64'(1));
            check("stream_sel", 64'(a_out_sel), 64'(k));
            check("stream_data", 64'(a_out_data), 64'(k * 32'h11111111));
        end
        a_in_valid = 1'b0;
        step();
        check("stream_xfer", 64'(a_xfer_count), 64'(8));

        // Backpressure for three cycles.
        do_reset(1);
        a_out_ready = 1'b0; a_in_valid = 1'b1;
        acc0 = dut_acc;
        for (int i = 0; i < 3; i++) begin
            a_sel = 3'($urandom_range(0, N - 1));
            step();
        end
        check("bp_accepted", 64'(dut_acc - acc0), 64'(CAP));
        check("bp_in_ready", 64'(a_in_ready), 64'(0));
        a_out_ready = 1'b1; a_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("bp_xfer", 64'(a_xfer_count), 64'(CAP));

        // Reset while stalled.
        a_out_ready = 1'b0; a_in_valid = 1'b1;
        step(); step();
        check("stall_valid", 64'(a_out_valid), 64'(1));
        a_reset = 1'b1;
        step();
        check("mid_rst_valid", 64'(a_out_valid), 64'(0));
        check("mid_rst_xfer", 64'(a_xfer_count), 64'(0));
        a_reset = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
        step();

        // Random traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < N; k++) a_in_data[k*W +: W] = $urandom();
            a_sel       = 3'($urandom_range(0, N - 1));
            a_in_valid  = 1'($urandom_range(0, 1));
            a_out_ready = 1'($urandom_range(0, 3) != 0);
            a_reset     = 1'($urandom_range(0, 49) == 0);
            step();
        end
        a_reset = 1'b0;

        // Out-of-range select on the 5-channel, 16-bit instance.
        b_reset = 1'b0; b_sel = 3'd6; b_in_valid = 1'b1; b_out_ready = 1'b1;
        step();
        check("oor_valid", 64'(b_out_valid), 64'(1));
        check("oor_data", 64'(b_out_data), 64'(0));
        check("oor_err", 64'(b_out_err), 64'(1));
        check("oor_sel", 64'(b_out_sel), 64'(6));
        b_sel = 3'd3;
        step();
        check("inr_data", 64'(b_out_data), 64'(16'h1003));
        check("inr_err", 64'(b_out_err), 64'(0));
        check("inr_sel", 64'(b_out_sel), 64'(3));
        check("inr_xfer", 64'(b_xfer_count), 64'(1));
        b_in_valid = 1'b0;
        step();
        check("b_idle_valid", 64'(b_out_valid), 64'(0));
        check("b_xfer", 64'(b_xfer_count), 64'(2));

        // Counter wrap after 65537 transfers.
        do_reset(1);
        a_in_valid = 1'b1; a_out_ready = 1'b1; a_sel = 3'd2;
        for (int i = 0; i < 70000 && total < 65537; i++) step();
        a_in_valid = 1'b0;
        check("wrap_reached", 64'(total >= 65537), 64'(1));
        check("wrap_xfer", 64'(a_xfer_count), 64'(1));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
